// File: rtl/memory_read_arbiter.sv
// Two-port (fetch/data) read arbiter for a single synchronous-read RAM port.
// The optional grant/conflict counters are enabled by defining MEMORY_READ_ARBITER_STATS_EN.
module memory_read_arbiter #(
    parameter int MEM_DEPTH    = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [12:0] f_addr,
    output logic        f_ack,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic [12:0] d_addr,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic        f_err,
    output logic [12:0] mem_read_address,
    input  logic [15:0] mem_value
`ifdef MEMORY_READ_ARBITER_STATS_EN
    ,
    output logic [15:0] stat_f_grants,
    output logic [15:0] stat_d_grants,
    output logic [15:0] stat_conflicts
`endif
);

    typedef enum logic [2:0] {
        RESP_NONE,
        RESP_F,
        RESP_F_ERR,
        RESP_D,
        RESP_D_ERR
    } resp_t;

    resp_t       resp_sel, resp_next;
    logic [3:0]  starve_cnt, starve_next;
    logic [12:0] addr_q;
    logic [15:0] f_hold, d_hold;
    logic        f_win, d_win, f_force, f_oor, d_oor;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        f_force          = (starve_cnt == 4'(STARVE_LIMIT));
        f_win            = f_req && (!d_req || f_force);
        d_win            = d_req && !f_win;
        f_oor            = 32'(f_addr) >= 32'(MEM_DEPTH);
        d_oor            = 32'(d_addr) >= 32'(MEM_DEPTH);
        f_ack            = f_win && !reset;
        d_ack            = d_win && !reset;
        mem_read_address = addr_q;
        resp_next        = RESP_NONE;
        starve_next      = 4'd0;

        if (reset) begin
            mem_read_address = 13'd0;
        end else if (f_win) begin
            mem_read_address = f_addr;
            resp_next        = f_oor ? RESP_F_ERR : RESP_F;
        end else if (d_win) begin
            mem_read_address = d_addr;
            resp_next        = d_oor ? RESP_D_ERR : RESP_D;
        end

        // A D grant only counts against F while F is actually waiting.
        if (d_win && f_req) begin
            starve_next = f_force ? starve_cnt : starve_cnt + 4'd1;
        end
    end

    // The RAM registers its output, so response data is steered straight from mem_value.
    always_comb begin
        f_rvalid = (resp_sel == RESP_F) || (resp_sel == RESP_F_ERR);
        d_rvalid = (resp_sel == RESP_D) || (resp_sel == RESP_D_ERR);
        f_err    = (resp_sel == RESP_F_ERR);
        d_err    = (resp_sel == RESP_D_ERR);
        f_rdata  = f_hold;
        d_rdata  = d_hold;
        case (resp_sel)
            RESP_F:     f_rdata = mem_value;
            RESP_F_ERR: f_rdata = 16'h0000;
            RESP_D:     d_rdata = mem_value;
            RESP_D_ERR: d_rdata = 16'h0000;
            default:    ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_sel   <= RESP_NONE;
            starve_cnt <= 4'd0;
            addr_q     <= 13'd0;
            f_hold     <= 16'h0000;
            d_hold     <= 16'h0000;
        end else begin
            resp_sel   <= resp_next;
            starve_cnt <= starve_next;
            addr_q     <= mem_read_address;
            f_hold     <= f_rdata;
            d_hold     <= d_rdata;
        end
    end

`ifdef MEMORY_READ_ARBITER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_f_grants  <= 16'h0000;
            stat_d_grants  <= 16'h0000;
            stat_conflicts <= 16'h0000;
        end else begin
            if (f_win && stat_f_grants != 16'hFFFF) begin
                stat_f_grants <= stat_f_grants + 16'd1;
            end
            if (d_win && stat_d_grants != 16'hFFFF) begin
                stat_d_grants <= stat_d_grants + 16'd1;
            end
            if (f_req && d_req && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed scoreboard bench for memory_read_arbiter with a behavioural 1-cycle-latency RAM.
module tb_memory_read_arbiter;

    localparam int MEM_DEPTH = 32;

    typedef struct {
        int          port;   // 0 none, 1 F, 2 D
        logic        err;
        logic [15:0] data;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req, d_req;
    logic [12:0] f_addr, d_addr;
    logic        f_ack, f_rvalid, f_err, d_ack, d_rvalid, d_err;
    logic [15:0] f_rdata, d_rdata;
    logic [12:0] mem_read_address;
    logic [15:0] mem_value = 16'h0000;
`ifdef MEMORY_READ_ARBITER_STATS_EN
    logic [15:0] stat_f_grants, stat_d_grants, stat_conflicts;
`endif

    logic [15:0] ram [0:8191];
    resp_t       sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_f_rdata = 16'h0000;
    logic [15:0] exp_d_rdata = 16'h0000;
    logic [12:0] exp_addr    = 13'd0;
    int          conflict_pat [8] = '{2, 2, 2, 1, 2, 2, 2, 1};

    memory_read_arbiter #(.MEM_DEPTH(MEM_DEPTH), .STARVE_LIMIT(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .f_req            (f_req),
        .f_addr           (f_addr),
        .f_ack            (f_ack),
        .f_rvalid         (f_rvalid),
        .f_rdata          (f_rdata),
        .d_req            (d_req),
        .d_addr           (d_addr),
        .d_ack            (d_ack),
        .d_rvalid         (d_rvalid),
        .d_rdata          (d_rdata),
        .d_err            (d_err),
        .f_err            (f_err),
        .mem_read_address (mem_read_address),
        .mem_value        (mem_value)
`ifdef MEMORY_READ_ARBITER_STATS_EN
        ,
        .stat_f_grants    (stat_f_grants),
        .stat_d_grants    (stat_d_grants),
        .stat_conflicts   (stat_conflicts)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_value <= ram[mem_read_address];

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [12:0] fa, input logic dr, input logic [12:0] da);
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_addr = da;
    endtask

    task automatic clear_expect();
        resp_t n;
        n.port = 0; n.err = 1'b0; n.data = 16'h0000;
        sb.delete();
        sb.push_back(n);
        exp_f_rdata = 16'h0000;
        exp_d_rdata = 16'h0000;
        exp_addr    = 13'd0;
    endtask

    // Checks the response owed for the previous cycle, then this cycle's grant; g: 0 none, 1 F, 2 D.
    task automatic step(input string tag, input int g);
        resp_t       r, e;
        logic [12:0] a;
        @(negedge clock);
        if (sb.size() == 0) begin
            r.port = 0; r.err = 1'b0; r.data = 16'h0000;
        end else begin
            r = sb.pop_front();
        end
        if (r.port == 1) exp_f_rdata = r.data;
        if (r.port == 2) exp_d_rdata = r.data;
        chk({tag, ":f_rvalid"}, 32'(f_rvalid), 32'(r.port == 1));
        chk({tag, ":f_err"},    32'(f_err),    32'(r.port == 1 && r.err));
        chk({tag, ":f_rdata"},  32'(f_rdata),  32'(exp_f_rdata));
        chk({tag, ":d_rvalid"}, 32'(d_rvalid), 32'(r.port == 2));
        chk({tag, ":d_err"},    32'(d_err),    32'(r.port == 2 && r.err));
        chk({tag, ":d_rdata"},  32'(d_rdata),  32'(exp_d_rdata));
        chk({tag, ":f_ack"},    32'(f_ack),    32'(g == 1));
        chk({tag, ":d_ack"},    32'(d_ack),    32'(g == 2));
        a = (g == 1) ? f_addr : d_addr;
        if (g != 0) exp_addr = a;
        chk({tag, ":mem_addr"}, 32'(mem_read_address), 32'(exp_addr));
        e.port = g;
        e.err  = (g != 0) && (32'(a) >= MEM_DEPTH);
        e.data = (g == 0 || e.err) ? 16'h0000 : ram[a];
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 16'(i * 16'h0101) ^ 16'h5a5a;
        ram[0] = 16'h8001;
        ram[1] = 16'h6040;
        ram[2] = 16'h8002;
        ram[4] = 16'h0000;
        clear_expect();

        // Reset state, with requests present to show acks stay gated
        reset = 1'b1;
        drive(1'b1, 13'd1, 1'b1, 13'd2);
        #3;
        chk("rst:f_ack", 32'(f_ack), 32'd0);
        chk("rst:d_ack", 32'(d_ack), 32'd0);
        chk("rst:mem_addr", 32'(mem_read_address), 32'd0);
        chk("rst:rvalid", 32'({f_rvalid, d_rvalid, f_err, d_err}), 32'd0);
        chk("rst:rdata", {f_rdata, d_rdata}, 32'd0);
        @(posedge clock);
        #1;
        chk("rst_edge:rvalid", 32'({f_rvalid, d_rvalid}), 32'd0);
        chk("rst_edge:mem_addr", 32'(mem_read_address), 32'd0);

        // Continuous conflict: D,D,D,F repeating
        reset = 1'b0;
        drive(1'b1, 13'd0, 1'b1, 13'd2);
        for (int i = 0; i < 8; i++) step($sformatf("conflict%0d", i), conflict_pat[i]);
`ifdef MEMORY_READ_ARBITER_STATS_EN
        chk("stat_d_grants",  32'(stat_d_grants),  32'd6);
        chk("stat_f_grants",  32'(stat_f_grants),  32'd2);
        chk("stat_conflicts", 32'(stat_conflicts), 32'd8);
`endif
        drive(1'b0, 13'd0, 1'b0, 13'd0);
        step("conflict_tail", 0);

        // Single fetch
        drive(1'b1, 13'd1, 1'b0, 13'd0);
        step("fetch", 1);
        drive(1'b0, 13'd0, 1'b0, 13'd0);
        step("fetch_resp", 0);
        chk("fetch_data", 32'(f_rdata), 32'h6040);

        // Back-to-back data reads
        drive(1'b0, 13'd0, 1'b1, 13'd0);
        step("b2b0", 2);
        d_addr = 13'd2;
        step("b2b1", 2);
        d_addr = 13'd4;
        step("b2b2", 2);
        drive(1'b0, 13'd0, 1'b0, 13'd0);
        step("b2b_tail", 0);
        step("idle_hold", 0);

        // Out-of-range addresses on each port
        drive(1'b0, 13'd0, 1'b1, 13'd40);
        step("oor_d", 2);
        drive(1'b1, 13'd40, 1'b0, 13'd0);
        step("oor_f", 1);
        drive(1'b1, 13'd5, 1'b1, 13'd31);
        step("edge_d31", 2);
        drive(1'b1, 13'd5, 1'b0, 13'd0);
        step("after_oor_f", 1);
        drive(1'b0, 13'd0, 1'b0, 13'd0);
        step("oor_tail", 0);

        // Reset arriving mid-way through the response cycle of a fetch
        drive(1'b1, 13'd3, 1'b0, 13'd0);
        step("pre_rst", 1);
        drive(1'b0, 13'd0, 1'b0, 13'd0);
        #1;
        chk("pre_rst:f_rvalid", 32'(f_rvalid), 32'd1);
        chk("pre_rst:f_rdata", 32'(f_rdata), 32'(ram[3]));
        reset = 1'b1;
        #1;
        chk("mid_rst:f_rvalid", 32'(f_rvalid), 32'd0);
        chk("mid_rst:f_rdata", 32'(f_rdata), 32'd0);
        @(posedge clock);
        #1;
        chk("post_rst_edge:f_rvalid", 32'(f_rvalid), 32'd0);
        reset = 1'b0;
        clear_expect();

        // Build starvation up to the limit, then reset: the next conflict must go to D again
        drive(1'b1, 13'd0, 1'b1, 13'd2);
        for (int i = 0; i < 3; i++) step($sformatf("starve%0d", i), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("starve_rst:acks", 32'({f_ack, d_ack}), 32'd0);
        chk("starve_rst:d_rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_expect();
        step("post_rst_conflict", 2);
        drive(1'b0, 13'd0, 1'b0, 13'd0);
        step("final_resp", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
